// File: rtl/rs_age_select_if.sv
// Bus bundle for rs_age_select: dispatch port, CDB broadcast, issue port,
// squash and occupancy. The master drives dispatch/CDB/issue_ready/squash;
// the slave is the reservation station.
interface rs_age_select_if #(
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64,
  parameter int IDX_W     = 3
);
  logic                 dispatch_valid;
  logic                 dispatch_ready;
  logic                 dispatch_t1_valid;
  logic                 dispatch_t2_valid;
  logic                 dispatch_t1_ready;
  logic                 dispatch_t2_ready;
  logic [TAG_W-1:0]     dispatch_t1_tag;
  logic [TAG_W-1:0]     dispatch_t2_tag;
  logic [TAG_W-1:0]     dispatch_dest_tag;
  logic [PAYLOAD_W-1:0] dispatch_payload;
  logic                 cdb_en;
  logic [TAG_W-1:0]     cdb_tag;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [IDX_W-1:0]     issue_idx;
  logic [TAG_W-1:0]     issue_dest_tag;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic                 squash;
  logic [IDX_W:0]       free_count;

  modport master (
    output dispatch_valid, dispatch_t1_valid, dispatch_t2_valid,
           dispatch_t1_ready, dispatch_t2_ready, dispatch_t1_tag, dispatch_t2_tag,
           dispatch_dest_tag, dispatch_payload, cdb_en, cdb_tag, issue_ready, squash,
    input  dispatch_ready, issue_valid, issue_idx, issue_dest_tag, issue_payload,
           free_count
  );

  modport slave (
    input  dispatch_valid, dispatch_t1_valid, dispatch_t2_valid,
           dispatch_t1_ready, dispatch_t2_ready, dispatch_t1_tag, dispatch_t2_tag,
           dispatch_dest_tag, dispatch_payload, cdb_en, cdb_tag, issue_ready, squash,
    output dispatch_ready, issue_valid, issue_idx, issue_dest_tag, issue_payload,
           free_count
  );
endinterface

// File: rtl/rs_age_select.sv
// Reservation station with DEPTH entries: dispatch into the lowest free slot,
// CDB wakeup (including same-cycle bypass on dispatch), one issue per cycle.
// Optional macro RS_AGE_SELECT_EN: keep a DEPTH x DEPTH age matrix and issue
// the oldest ready entry; otherwise the lowest-index ready entry issues.
module rs_age_select #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input logic            clock,
  input logic            reset,
  rs_age_select_if.slave bus
);
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     t1_valid;
  logic [DEPTH-1:0]     t1_ready;
  logic [DEPTH-1:0]     t2_valid;
  logic [DEPTH-1:0]     t2_ready;
  logic [TAG_W-1:0]     t1_tag   [DEPTH];
  logic [TAG_W-1:0]     t2_tag   [DEPTH];
  logic [TAG_W-1:0]     dest_tag [DEPTH];
  logic [PAYLOAD_W-1:0] payload  [DEPTH];

  logic [DEPTH-1:0] cand;
  logic [IDX_W:0]   busy_count;
  logic [IDX_W:0]   free_count;
  logic [IDX_W-1:0] alloc_idx;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             do_dispatch;
  logic             do_free;
  logic             byp_t1;
  logic             byp_t2;

  // Issue candidates, occupancy and lowest free slot, all from registered state
  always_comb begin
    cand       = '0;
    busy_count = '0;
    alloc_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i]    = busy[i] && (!t1_valid[i] || t1_ready[i]) && (!t2_valid[i] || t2_ready[i]);
      busy_count = busy_count + {{IDX_W{1'b0}}, busy[i]};
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) alloc_idx = IDX_W'(i);
      else          alloc_idx = alloc_idx;
    end
  end

  assign free_count  = (IDX_W+1)'(DEPTH) - busy_count;
  assign sel_valid   = |cand;
  // Squash wins over every state update in the same cycle
  assign do_dispatch = bus.dispatch_valid && bus.dispatch_ready && !bus.squash;
  assign do_free     = sel_valid && bus.issue_ready && !bus.squash;
  assign byp_t1      = bus.cdb_en && bus.dispatch_t1_valid && (bus.dispatch_t1_tag == bus.cdb_tag);
  assign byp_t2      = bus.cdb_en && bus.dispatch_t2_valid && (bus.dispatch_t2_tag == bus.cdb_tag);

`ifdef RS_AGE_SELECT_EN
  // older[j][k] set means entry j was dispatched before entry k
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] blocked;

  // Pick the candidate that no other candidate is older than
  always_comb begin
    blocked = '0;
    sel_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (cand[j] && older[j][k]) blocked[k] = 1'b1;
        else                        blocked[k] = blocked[k];
      end
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (cand[k] && !blocked[k]) sel_idx = IDX_W'(k);
      else                        sel_idx = sel_idx;
    end
  end

  // New entry becomes younger than every occupied entry; its own row is cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (do_dispatch) begin
      for (int j = 0; j < DEPTH; j++) begin
        older[j][alloc_idx] <= (j != int'(alloc_idx)) ? busy[j] : 1'b0;
      end
      older[alloc_idx] <= '0;
    end
  end
`else
  // Fixed priority: lowest-index candidate wins
  always_comb begin
    sel_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (cand[k]) sel_idx = IDX_W'(k);
      else         sel_idx = sel_idx;
    end
  end
`endif

  // Entry storage: squash, wakeup, free on issue handshake, dispatch write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      t1_valid <= '0;
      t1_ready <= '0;
      t2_valid <= '0;
      t2_ready <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        t1_tag[i]   <= '0;
        t2_tag[i]   <= '0;
        dest_tag[i] <= '0;
        payload[i]  <= '0;
      end
    end else if (bus.squash) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.cdb_en && busy[i] && t1_valid[i] && (t1_tag[i] == bus.cdb_tag)) t1_ready[i] <= 1'b1;
        if (bus.cdb_en && busy[i] && t2_valid[i] && (t2_tag[i] == bus.cdb_tag)) t2_ready[i] <= 1'b1;
      end
      if (do_free) busy[sel_idx] <= 1'b0;
      if (do_dispatch) begin
        busy[alloc_idx]     <= 1'b1;
        t1_valid[alloc_idx] <= bus.dispatch_t1_valid;
        t1_ready[alloc_idx] <= bus.dispatch_t1_ready || byp_t1;
        t1_tag[alloc_idx]   <= bus.dispatch_t1_tag;
        t2_valid[alloc_idx] <= bus.dispatch_t2_valid;
        t2_ready[alloc_idx] <= bus.dispatch_t2_ready || byp_t2;
        t2_tag[alloc_idx]   <= bus.dispatch_t2_tag;
        dest_tag[alloc_idx] <= bus.dispatch_dest_tag;
        payload[alloc_idx]  <= bus.dispatch_payload;
      end
    end
  end

  assign bus.dispatch_ready = (free_count != '0);
  assign bus.free_count     = free_count;
  assign bus.issue_valid    = sel_valid;
  assign bus.issue_idx      = sel_valid ? sel_idx : '0;
  assign bus.issue_dest_tag = sel_valid ? dest_tag[sel_idx] : '0;
  assign bus.issue_payload  = sel_valid ? payload[sel_idx] : '0;
endmodule
